// File: rtl/inst_fetch_responder_pkg.sv
// inst_fetch_responder_pkg: shared fetch-path types and AXI encodings.
package inst_fetch_responder_pkg;
    typedef logic [31:0] virt_t;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         FETCH_W        = 64;
endpackage

// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: uncached instruction fetch as 2-beat AXI reads, in-order return, flush drain.
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AXI_ID          = 4'd0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               icache_req,
    input  virt_t              icache_addr,
    output logic               icache_addr_ok,
    output logic               icache_data_ok,
    output logic [FETCH_W-1:0] icache_rdata,
    output logic               icache_bus_err,
    output logic [3:0]         arid,
    output virt_t              araddr,
    output logic [7:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    output logic               arvalid,
    input  logic               arready,
    input  logic [3:0]         rid,
    input  logic [31:0]        rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast,
    input  logic               rvalid,
    output logic               rready
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

    logic               arvalid_q, arvalid_d;
    virt_t              araddr_q, araddr_d;
    logic [CW-1:0]      cnt_q, cnt_d, cancel_q, cancel_d;
    logic [31:0]        lo_q, lo_d;
    logic               err_q, err_d;
    logic               data_ok_q, data_ok_d;
    logic [FETCH_W-1:0] rdata_q, rdata_d;
    logic               bus_err_q, bus_err_d;
    logic               accept, r_lo, r_last, beat_err;
    logic               unused_ok;

    always_comb begin
        accept    = resetn && icache_req && !flush && (cnt_q < MAX_C) && (!arvalid_q || arready);
        r_lo      = rvalid && !rlast;
        r_last    = rvalid && rlast;
        beat_err  = rresp != AXI_RESP_OKAY;
        arvalid_d = accept ? 1'b1 : (arready ? 1'b0 : arvalid_q);
        araddr_d  = accept ? {icache_addr[31:3], 3'b000} : araddr_q;
        cnt_d     = cnt_q + CW'(accept) - CW'(r_last);
        // flush reloads with the post-completion count, so a same-cycle rlast is already excluded
        cancel_d  = flush ? cnt_d : (r_last && cancel_q != '0) ? cancel_q - CW'(1) : cancel_q;
        lo_d      = r_lo ? rdata : lo_q;
        err_d     = r_last ? 1'b0 : (err_q | (r_lo & beat_err));
        data_ok_d = r_last && !flush && cancel_q == '0;
        rdata_d   = data_ok_d ? {rdata, lo_q} : rdata_q;
        bus_err_d = data_ok_d ? (err_q | beat_err) : bus_err_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            cnt_q     <= '0;
            cancel_q  <= '0;
            lo_q      <= '0;
            err_q     <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            cnt_q     <= cnt_d;
            cancel_q  <= cancel_d;
            lo_q      <= lo_d;
            err_q     <= err_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign icache_addr_ok = accept;
    assign icache_data_ok = data_ok_q && !flush;
    assign icache_rdata   = rdata_q;
    assign icache_bus_err = bus_err_q && icache_data_ok;
    assign arid           = AXI_ID;
    assign araddr         = araddr_q;
    assign arlen          = 8'd1;
    assign arsize         = AXI_SIZE_4B;
    assign arburst        = AXI_BURST_INCR;
    assign arvalid        = arvalid_q;
    assign rready         = 1'b1;
    // single ID, in-order responses; low address bits are implied by alignment
    assign unused_ok      = ^{rid, icache_addr[2:0]};
endmodule

// File: tb/tb_inst_fetch_responder.sv
// tb_inst_fetch_responder: directed stimulus with a return scoreboard for inst_fetch_responder.
module tb_inst_fetch_responder;
    logic        clk = 1'b0, resetn = 1'b0, flush = 1'b0, icache_req = 1'b0;
    logic [31:0] icache_addr = '0;
    logic        icache_addr_ok, icache_data_ok, icache_bus_err;
    logic [63:0] icache_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready = 1'b1;
    logic [3:0]  rid = '0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0, rvalid = 1'b0, rready;

    int checks = 0, errors = 0, pushes = 0, data_ok_seen = 0;
    logic [64:0] sb[$];

    inst_fetch_responder dut (
        .clk(clk), .resetn(resetn), .flush(flush), .icache_req(icache_req),
        .icache_addr(icache_addr), .icache_addr_ok(icache_addr_ok),
        .icache_data_ok(icache_data_ok), .icache_rdata(icache_rdata),
        .icache_bus_err(icache_bus_err), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
        .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] r, input logic l);
        rvalid = 1'b1; rdata = d; rresp = r; rlast = l;
        tick();
        rvalid = 1'b0; rlast = 1'b0; rresp = '0;
    endtask

    task automatic burst(input logic [31:0] lo, input logic [31:0] hi,
                         input logic [1:0] r0, input logic [1:0] r1, input logic keep);
        beat(lo, r0, 1'b0);
        if (keep) begin
            sb.push_back({(r0 != 2'b00) || (r1 != 2'b00), hi, lo});
            pushes++;
        end
        beat(hi, r1, 1'b1);
    endtask

    // scoreboard: every data_ok must match the oldest expected return
    always @(negedge clk) begin
        if (resetn && icache_data_ok) begin
            logic [64:0] e;
            data_ok_seen++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_data_ok observed=%h expected=none", icache_rdata);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rdata", icache_rdata, e[63:0]);
                chk("bus_err", {63'd0, icache_bus_err}, {63'd0, e[64]});
            end
        end
    end

    initial begin
        icache_req = 1'b1;
        #2;
        chk("rst_addr_ok", {63'd0, icache_addr_ok}, 64'd0);
        chk("rst_arvalid", {63'd0, arvalid}, 64'd0);
        chk("rst_data_ok", {63'd0, icache_data_ok}, 64'd0);
        chk("rst_araddr", {32'd0, araddr}, 64'd0);
        icache_req = 1'b0;
        #10 resetn = 1'b1;
        tick();
        // single fetch
        icache_req = 1'b1; icache_addr = 32'hbfc0_0004; arready = 1'b1;
        #1 chk("t1_addr_ok", {63'd0, icache_addr_ok}, 64'd1);
        tick();
        icache_req = 1'b0;
        chk("t1_arvalid", {63'd0, arvalid}, 64'd1);
        chk("t1_araddr", {32'd0, araddr}, 64'hbfc0_0000);
        chk("t1_arconst", {43'd0, arid, arlen, arsize, arburst, rready}, {43'd0, 4'd0, 8'd1, 3'b010, 2'b01, 1'b1});
        tick();
        chk("t1_ar_clear", {63'd0, arvalid}, 64'd0);
        burst(32'h3c08_bfc0, 32'h3508_0000, 2'b00, 2'b00, 1'b1);
        chk("t1_data_ok", {63'd0, icache_data_ok}, 64'd1);
        tick();
        chk("t1_pulse", {63'd0, icache_data_ok}, 64'd0);
        // back-pressure and outstanding limit
        arready = 1'b0; icache_req = 1'b1; icache_addr = 32'h0000_1000;
        #1 chk("t2_acc_a", {63'd0, icache_addr_ok}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_stall_ok", {63'd0, icache_addr_ok}, 64'd0);
            chk("t2_araddr", {32'd0, araddr}, 64'h0000_1000);
        end
        arready = 1'b1; icache_addr = 32'h0000_2008;
        #1 chk("t2_acc_b", {63'd0, icache_addr_ok}, 64'd1);
        tick();
        chk("t2_araddr_b", {32'd0, araddr}, 64'h0000_2008);
        chk("t2_limit", {63'd0, icache_addr_ok}, 64'd0);
        tick();
        chk("t2_limit2", {63'd0, icache_addr_ok}, 64'd0);
        icache_req = 1'b0;
        beat(32'h1111_0000, 2'b00, 1'b0);
        sb.push_back({1'b0, 32'h1111_0001, 32'h1111_0000}); pushes++;
        rvalid = 1'b1; rdata = 32'h1111_0001; rlast = 1'b1; icache_req = 1'b1;
        #1 chk("t2_full_at_rlast", {63'd0, icache_addr_ok}, 64'd0);
        icache_req = 1'b0;
        tick();
        rvalid = 1'b0; rlast = 1'b0; icache_req = 1'b1;
        #1 chk("t2_slot_free", {63'd0, icache_addr_ok}, 64'd1);
        icache_req = 1'b0;
        burst(32'h2222_0000, 32'h2222_0001, 2'b00, 2'b00, 1'b1);
        tick();
        // flush with two outstanding
        icache_req = 1'b1; icache_addr = 32'h0000_3000;
        tick();
        icache_addr = 32'h0000_3008;
        tick();
        flush = 1'b1;
        #1 chk("t3_flush_block", {63'd0, icache_addr_ok}, 64'd0);
        tick();
        flush = 1'b0; icache_req = 1'b0;
        burst(32'h3333_0000, 32'h3333_0001, 2'b00, 2'b00, 1'b0);
        burst(32'h3333_0002, 32'h3333_0003, 2'b00, 2'b00, 1'b0);
        tick();
        chk("t3_no_data", data_ok_seen, pushes);
        // flush then new request overtaking the drain
        icache_req = 1'b1; icache_addr = 32'h0000_4000;
        tick();
        icache_req = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; icache_req = 1'b1; icache_addr = 32'hbfc0_0100;
        #1 chk("t4_post_flush_acc", {63'd0, icache_addr_ok}, 64'd1);
        tick();
        icache_req = 1'b0;
        chk("t4_araddr", {32'd0, araddr}, 64'hbfc0_0100);
        burst(32'h4444_0000, 32'h4444_0001, 2'b00, 2'b00, 1'b0);
        burst(32'h5555_0000, 32'h5555_0001, 2'b00, 2'b00, 1'b1);
        tick();
        // rlast coinciding with flush is dropped
        icache_req = 1'b1; icache_addr = 32'h0000_6000;
        tick();
        icache_req = 1'b0;
        beat(32'h6666_0000, 2'b00, 1'b0);
        flush = 1'b1;
        beat(32'h6666_0001, 2'b00, 1'b1);
        flush = 1'b0;
        chk("t4_flush_rlast", {63'd0, icache_data_ok}, 64'd0);
        // error responses
        icache_req = 1'b1; icache_addr = 32'h0000_7000;
        tick();
        icache_req = 1'b0;
        burst(32'h7777_0000, 32'h7777_0001, 2'b10, 2'b00, 1'b1);
        chk("t5_err", {62'd0, icache_data_ok, icache_bus_err}, 64'd3);
        icache_req = 1'b1; icache_addr = 32'h0000_7100;
        tick();
        icache_req = 1'b0;
        burst(32'h7777_0002, 32'h7777_0003, 2'b00, 2'b00, 1'b1);
        chk("t5_clean", {62'd0, icache_data_ok, icache_bus_err}, 64'd2);
        tick();
        // async reset mid-burst
        icache_req = 1'b1; icache_addr = 32'h0000_8000; arready = 1'b0;
        tick();
        icache_req = 1'b0;
        beat(32'hdead_beef, 2'b10, 1'b0);
        #2 resetn = 1'b0; icache_req = 1'b1;
        #1;
        chk("t6_rst_arvalid", {63'd0, arvalid}, 64'd0);
        chk("t6_rst_addr_ok", {63'd0, icache_addr_ok}, 64'd0);
        chk("t6_rst_araddr", {32'd0, araddr}, 64'd0);
        icache_req = 1'b0; arready = 1'b1;
        tick();
        resetn = 1'b1;
        tick();
        icache_req = 1'b1; icache_addr = 32'h0000_9004;
        tick();
        icache_req = 1'b0;
        chk("t6_araddr", {32'd0, araddr}, 64'h0000_9000);
        burst(32'h9999_0000, 32'h9999_0001, 2'b00, 2'b00, 1'b1);
        tick();
        tick();
        chk("sb_empty", sb.size(), 0);
        chk("data_ok_total", data_ok_seen, pushes);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
